// File: rtl/dso_pkg.sv
// Shared types and constants for the DSO capture path.
// Holds the capture state encoding and the trigger source codes.
package dso_pkg;

    localparam int SMPL_W = 8;
    localparam int NUM_CH = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

    // Source select: bit 1 set means force, bit 0 is then don't-care.
    localparam logic [1:0] TRIG_CH1   = 2'b00;
    localparam logic [1:0] TRIG_CH2   = 2'b01;
    localparam logic [1:0] TRIG_FORCE = 2'b10;

endpackage

// File: rtl/dso_capture_if.sv
// Sample RAM write port between the capture controller and the RAM.
interface dso_capture_if #(
    parameter int AW = 9
);
    logic                                       we;
    logic [AW-1:0]                              waddr;
    logic [dso_pkg::NUM_CH*dso_pkg::SMPL_W-1:0] wdata;

    modport master (output we, waddr, wdata);
    modport slave  (input  we, waddr, wdata);
endinterface

// File: rtl/dso_capture_trig_detect.sv
// Trigger comparator synchronizers, edge detection and source/edge select.
// Produces a registered single-cycle event, three clocks after a pin change.
module trig_detect
    import dso_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       trig1,
    input  logic       trig2,
    input  logic [1:0] trig_src,
    input  logic       trig_edge,
    output logic       trig_evt
);

    // bit 0 follows trig1, bit 1 follows trig2
    logic [1:0] s1, s2, s3;
    logic [1:0] rise, fall;
    logic       evt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            trig_evt <= 1'b0;
        end else begin
            s1       <= {trig2, trig1};
            s2       <= s1;
            s3       <= s2;
            trig_evt <= evt_d;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_comb begin
        evt_d = 1'b0;
        if (|(trig_src & TRIG_FORCE))
            evt_d = 1'b1;
        else if (trig_src == TRIG_CH1)
            evt_d = trig_edge ? rise[0] : fall[0];
        else
            evt_d = trig_edge ? rise[1] : fall[1];
    end

endmodule

// File: rtl/dso_capture.sv
// Capture controller: decimates A2D samples into a circular sample RAM,
// waits for the selected trigger and stops after trig_pos post-trigger writes.
module dso_capture
    import dso_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smpl_en,
    input  logic [SMPL_W-1:0] ch1_data,
    input  logic [SMPL_W-1:0] ch2_data,
    input  logic [SMPL_W-1:0] ch3_data,
    input  logic              trig1,
    input  logic              trig2,
    input  logic              start,
    input  logic [1:0]        trig_src,
    input  logic              trig_edge,
    input  logic [AW-1:0]     trig_pos,
    input  logic [3:0]        decimator,
    dso_capture_if.master     wr,
    output logic              armed,
    output logic              capture_done,
    output logic [AW-1:0]     trig_addr
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    cap_state_t state, state_nxt;

    logic                     trig_evt;
    logic [15:0]              dec_cnt;
    logic [15:0]              dec_mask;
    logic                     accept;
    logic                     wr_ok;
    logic                     wr_fire;
    logic                     done_set;
    logic [AW-1:0]            wptr;
    logic [AW:0]              wr_cnt;
    logic [AW-1:0]            post_cnt;
    logic [AW-1:0]            tp_eff;
    logic [AW:0]              pre_len;
    logic                     arm_last;
    logic                     post_last;
    logic                     we_q;
    logic [AW-1:0]            waddr_q;
    logic [NUM_CH*SMPL_W-1:0] wdata_q;

    trig_detect u_trig (
        .clk       (clk),
        .rst       (rst),
        .trig1     (trig1),
        .trig2     (trig2),
        .trig_src  (trig_src),
        .trig_edge (trig_edge),
        .trig_evt  (trig_evt)
    );

    // Keep one sample when the low 'decimator' bits of the count are all ones.
    assign dec_mask = ~(16'hFFFF << decimator);
    assign accept   = smpl_en && ((dec_cnt & dec_mask) == dec_mask);
    assign wr_fire  = accept && wr_ok;

    assign tp_eff    = (trig_pos == '0) ? AW'(1) : trig_pos;
    assign pre_len   = DEPTH - {1'b0, tp_eff};
    assign arm_last  = (wr_cnt + (AW+1)'(1)) == pre_len;
    assign post_last = (post_cnt + AW'(1)) == tp_eff;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ARM;
        end else begin
            case (state)
                IDLE:      state_nxt = IDLE;
                ARM:       if (wr_fire && arm_last) state_nxt = WAIT_TRIG;
                // A sample arriving with the event is already post-trigger.
                WAIT_TRIG: if (trig_evt)
                               state_nxt = (wr_fire && tp_eff == AW'(1)) ? DONE : POST;
                POST:      if (wr_fire && post_last) state_nxt = DONE;
                DONE:      state_nxt = DONE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ok    = 1'b0;
        armed    = 1'b0;
        done_set = 1'b0;
        case (state)
            ARM, POST: wr_ok = 1'b1;
            WAIT_TRIG: begin
                wr_ok = 1'b1;
                armed = 1'b1;
            end
            DONE:      done_set = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt      <= '0;
            wptr         <= '0;
            wr_cnt       <= '0;
            post_cnt     <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            trig_addr    <= '0;
            capture_done <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            // Registered from state so it trails the final write strobe by a clock.
            capture_done <= done_set && !start;
            if (start) begin
                dec_cnt  <= '0;
                wptr     <= '0;
                wr_cnt   <= '0;
                post_cnt <= '0;
                waddr_q  <= '0;
            end else begin
                if (smpl_en)
                    dec_cnt <= dec_cnt + 16'd1;
                if (wr_fire) begin
                    we_q    <= 1'b1;
                    waddr_q <= wptr;
                    wdata_q <= {ch3_data, ch2_data, ch1_data};
                    wptr    <= wptr + AW'(1);
                end
                if (state == ARM && wr_fire)
                    wr_cnt <= wr_cnt + (AW+1)'(1);
                if (state == WAIT_TRIG && trig_evt) begin
                    trig_addr <= wptr;
                    post_cnt  <= wr_fire ? AW'(1) : '0;
                end else if (state == POST && wr_fire) begin
                    post_cnt <= post_cnt + AW'(1);
                end
            end
        end
    end

    assign wr.we    = we_q;
    assign wr.waddr = waddr_q;
    assign wr.wdata = wdata_q;

endmodule

// File: tb/tb_dso_capture.sv
// Scoreboard bench for dso_capture: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares each write strobe.
module tb_dso_capture;
    import dso_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          smpl_en;
    logic [7:0]    ch1, ch2, ch3;
    logic          trig1, trig2, start;
    logic [1:0]    trig_src;
    logic          trig_edge;
    logic [AW-1:0] trig_pos;
    logic [3:0]    decimator;
    logic          armed, capture_done;
    logic [AW-1:0] trig_addr;

    dso_capture_if #(.AW(AW)) wr ();

    dso_capture #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .smpl_en      (smpl_en),
        .ch1_data     (ch1),
        .ch2_data     (ch2),
        .ch3_data     (ch3),
        .trig1        (trig1),
        .trig2        (trig2),
        .start        (start),
        .trig_src     (trig_src),
        .trig_edge    (trig_edge),
        .trig_pos     (trig_pos),
        .decimator    (decimator),
        .wr           (wr),
        .armed        (armed),
        .capture_done (capture_done),
        .trig_addr    (trig_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    logic [AW-1:0] exp_addr;
    int            seq;
    int            checks;
    int            failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sample, 4 clks apart; optionally check done timing on the final write.
    task automatic pulse(input bit exp, input bit chk_done = 1'b0);
        seq++;
        ch1 = seq[7:0];
        ch2 = 8'(seq * 3);
        ch3 = 8'hA5 ^ seq[7:0];
        smpl_en = 1'b1;
        if (exp) begin
            exp_q.push_back({exp_addr, ch3, ch2, ch1});
            exp_addr = exp_addr + 1'b1;
        end
        tick(1);
        smpl_en = 1'b0;
        if (chk_done) begin
            chk("done_low_on_strobe", capture_done, 0);
            tick(1);
            chk("done_after_strobe", capture_done, 1);
            tick(2);
        end else begin
            tick(3);
        end
    endtask

    task automatic pulses(input int n, input bit exp);
        for (int i = 0; i < n; i++) pulse(exp);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr.we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected: got addr %0d data %06h expected no write",
                             wr.waddr, wr.wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (wr.waddr != e.addr || wr.wdata != e.data) begin
                        failures++;
                        $display("FAIL wr_data: got addr %0d data %06h expected addr %0d data %06h",
                                 wr.waddr, wr.wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; seq = 0; exp_addr = '0;
        rst = 1'b1; smpl_en = 1'b0; start = 1'b0;
        ch1 = '0; ch2 = '0; ch3 = '0; trig1 = 1'b0; trig2 = 1'b0;
        trig_src = TRIG_CH1; trig_edge = 1'b1; trig_pos = 9'd256; decimator = 4'd0;
        tick(3);
        chk("rst_we", wr.we, 0);
        chk("rst_waddr", wr.waddr, 0);
        chk("rst_wdata", wr.wdata, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_trig_addr", trig_addr, 0);
        rst = 1'b0;
        tick(2);

        // Basic capture, rising trig1 after write 400
        do_start();
        pulses(400, 1'b1);
        chk("t1_armed", armed, 1);
        trig1 = 1'b1;
        tick(4);
        chk("t1_armed_post", armed, 0);
        pulses(255, 1'b1);
        chk("t1_done_early", capture_done, 0);
        pulse(1'b1, 1'b1);
        chk("t1_trig_addr", trig_addr, 400);
        chk("t1_q_empty", exp_q.size(), 0);
        pulses(3, 1'b0);
        chk("t1_done_hold", capture_done, 1);
        trig1 = 1'b0;
        tick(4);

        // Trigger edges during ARM are ignored
        do_start();
        chk("t2_done_drop", capture_done, 0);
        pulses(100, 1'b1);
        trig1 = 1'b1;
        tick(4);
        chk("t2_armed_100", armed, 0);
        trig1 = 1'b0;
        tick(4);
        pulses(155, 1'b1);
        chk("t2_armed_255", armed, 0);
        pulse(1'b1);
        chk("t2_armed_256", armed, 1);
        pulses(44, 1'b1);
        trig1 = 1'b1;
        tick(4);
        pulses(256, 1'b1);
        chk("t2_done", capture_done, 1);
        chk("t2_trig_addr", trig_addr, 300);
        trig1 = 1'b0;

        // Force trigger
        trig_src = TRIG_FORCE;
        do_start();
        pulses(512, 1'b1);
        chk("t3_done", capture_done, 1);
        chk("t3_trig_addr", trig_addr, 256);
        chk("t3_last_waddr", wr.waddr, 511);
        pulses(2, 1'b0);

        // Decimation by 4: pulses 4, 8, ..., 40 are written
        trig_src = TRIG_CH1;
        decimator = 4'd2;
        do_start();
        for (int k = 1; k <= 40; k++) pulse(k % 4 == 0);
        chk("t4_q_empty", exp_q.size(), 0);
        chk("t4_armed", armed, 0);
        decimator = 4'd0;

        // Falling trig2 after a fill that wraps waddr
        trig_src = TRIG_CH2;
        trig_edge = 1'b0;
        trig2 = 1'b1;
        tick(4);
        do_start();
        pulses(556, 1'b1);
        chk("t5_armed", armed, 1);
        trig2 = 1'b0;
        tick(4);
        chk("t5_armed_post", armed, 0);
        chk("t5_trig_addr", trig_addr, 44);
        pulses(100, 1'b1);
        do_start();
        chk("t5_restart_waddr", wr.waddr, 0);
        chk("t5_restart_done", capture_done, 0);
        pulses(10, 1'b1);

        // rst mid-POST
        trig_src = 2'b11;
        trig_pos = 9'd500;
        do_start();
        pulses(12, 1'b1);
        tick(4);
        pulses(20, 1'b1);
        chk("t6_trig_addr_pre", trig_addr, 12);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("t6_we", wr.we, 0);
        chk("t6_waddr", wr.waddr, 0);
        chk("t6_armed", armed, 0);
        chk("t6_done", capture_done, 0);
        chk("t6_trig_addr", trig_addr, 0);
        pulses(3, 1'b0);

        // trig_pos = 0 behaves as 1
        trig_src = TRIG_FORCE;
        trig_pos = '0;
        do_start();
        pulses(511, 1'b1);
        chk("t7_done_early", capture_done, 0);
        pulse(1'b1, 1'b1);
        chk("t7_trig_addr", trig_addr, 511);
        pulses(2, 1'b0);

        chk("final_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dso_capture.md
# dso_capture

Capture controller sitting directly downstream of the analog front end / A2D in the DSO. Each clock-enabled A2D sample of the three 8-bit channels is accepted (optionally decimated) and written into a circular sample RAM. The block detects the selected trigger comparator edge and stops after a programmed number of post-trigger samples. It reports the RAM address of the trigger point for readout.

## Interface
Parameters:
- AW, 9, sample RAM address width (depth 2^AW).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- smpl_en  in  1  one-clk pulse: new A2D sample valid on chN_data.
- ch1_data, ch2_data, ch3_data  in  8 each  unsigned A2D samples.
- trig1, trig2  in  1  trigger comparator outputs; asynchronous to clk.
- start  in  1  one-clk pulse: arm a new capture.
- trig_src  in  2  trigger source: 00 trig1, 01 trig2, 1x force (immediate).
- trig_edge  in  1  1 = rising, 0 = falling.
- trig_pos  in  AW  post-trigger sample count; 0 is treated as 1.
- decimator  in  4  keep one sample in every 2^decimator.
- we  out  1  RAM write strobe.
- waddr  out  AW  RAM write address.
- wdata  out  24  {ch3, ch2, ch1}.
- armed  out  1  high while waiting for a trigger.
- capture_done  out  1  high from capture end until the next start or rst.
- trig_addr  out  AW  address of the first post-trigger sample.

## Operation
- Trigger path: trig1 and trig2 each pass through 2 sync flops plus 1 history flop. Rising edge = s2 & ~s3; falling edge = ~s2 & s3. Mux selection is by trig_src and trig_edge. With force selected, the event is constant 1.
- Decimation: 16-bit dec_cnt increments on every smpl_en and clears on start. A sample is accepted when smpl_en is high and dec_cnt[decimator-1:0] is all ones. With decimator = 0, every sample is accepted.
- An accepted sample in ARM, WAIT_TRIG or POST produces a write. waddr then increments and wraps from 2^AW-1 to 0.
- States:
  - IDLE: no writes. start -> ARM.
  - ARM: clear waddr and write count. Write accepted samples. Trigger events are ignored. After 2^AW - trig_pos writes -> WAIT_TRIG.
  - WAIT_TRIG: armed = 1. Write circularly. On a trigger event, latch trig_addr = address of the next accepted sample, clear post_cnt -> POST.
  - POST: write accepted samples and increment post_cnt. On the write that makes post_cnt == trig_pos -> DONE.
  - DONE: capture_done = 1 and no writes. start -> ARM.
- A trigger event and an accepted sample in the same WAIT_TRIG cycle: that sample is the first post-trigger sample. It gets trig_addr = its address, post_cnt = 1, and the block goes to POST.
- start in any state restarts: the block goes to ARM and clears waddr, dec_cnt and counters. capture_done and armed drop on the next clk.
- rst at any time forces IDLE and the reset values below, including mid-POST.
- Reset values: we = 0, waddr = 0, wdata = 0, armed = 0, capture_done = 0, trig_addr = 0. Sync/history flops reset to 0.

## Timing
- we is a registered 1-clk pulse, asserted the cycle after the accepted smpl_en. waddr and wdata are valid in the same cycle as we.
- Trigger latency: a trig pin change is visible to the FSM 3 clks later (2 sync + edge flop).
- capture_done rises the cycle after the final POST write strobe.
- smpl_en pulses must be at least 2 clks apart (the A2D rate is far slower). Back-to-back pulses are undefined.

## Structure
- Shared package dso_pkg holds:
  - the capture state enum: IDLE, ARM, WAIT_TRIG, POST, DONE;
  - trig_src codes: TRIG_CH1 = 2'b00, TRIG_CH2 = 2'b01, TRIG_FORCE = 2'b1x;
  - the sample width constant (8).
- One sub-module, trig_detect: synchronizers, edge detect and source/edge mux, producing the single-cycle event.
- The FSM, counters and write-port registers stay in dso_capture.

## Test plan
- Reset: hold rst 2 clks mid-stream -> we = 0, waddr = 0, armed = 0, capture_done = 0, trig_addr = 0.
- Basic capture (AW = 9): trig_pos = 256, decimator = 0, trig_src = 00, rising edge, smpl_en every 4 clks with ramp data, trig1 rises after write 400 -> trig_addr = 400, exactly 256 further writes, capture_done = 1, no writes afterwards.
- Trigger ignored in ARM: trig_pos = 256, trig1 edge after write 100, second edge after write 300 -> armed = 0 until 256 writes, trig_addr = 300.
- Force: trig_src = 10, trig_pos = 256 -> trig_addr = 256, done after 512 total writes, last waddr = 511.
- Decimation and wrap: decimator = 2, 40 smpl_en -> 10 writes with wdata from pulses 4, 8, ..., 40. Pre-trigger fill longer than 512 writes wraps waddr 511 -> 0.
- Falling edge and restart: trig_edge = 0, trig2 falls -> trigger. start issued mid-POST -> ARM with waddr = 0 and capture_done remains 0. rst mid-POST -> IDLE.
